// File: rtl/product_accumulator.sv
// Accumulates a run of signed 32-bit products into a wide accumulator.
// The run result is saturated to 32 bits and held until the downstream consumer takes it.
module product_accumulator #(
   parameter int LEN_W = 8,
   parameter int ACC_W = 40
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [31:0]      prod,
   input  logic             prod_valid,
   output logic             prod_ready,
   output logic [31:0]      sum,
   output logic             sat,
   output logic             sum_valid,
   input  logic             sum_ready,
   output logic             busy,
   output logic [LEN_W-1:0] count
);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t                   state, state_next;
   logic signed [ACC_W-1:0]  acc, acc_next;
   logic signed [ACC_W-1:0]  prod_ext, acc_sum;
   logic [LEN_W-1:0]         len_latched, len_next;
   logic [LEN_W-1:0]         count_next, count_inc;
   logic [31:0]              sum_next;
   logic                     sat_next;
   logic                     transfer;
   logic [32:0]              clipped;

   // Returns {sat, sum}; the value fits in 32 bits only if all bits above bit 31 match bit 31.
   function automatic logic [32:0] saturate(input logic signed [ACC_W-1:0] a);
      logic [ACC_W-32:0] top;
      top = a[ACC_W-1:31];
      if ((&top) || !(|top))
         return {1'b0, a[31:0]};
      else if (a[ACC_W-1])
         return {1'b1, 32'h8000_0000};
      else
         return {1'b1, 32'h7FFF_FFFF};
   endfunction

   assign prod_ready = (state == ACC);
   assign sum_valid  = (state == DONE);
   assign busy       = (state != IDLE);

   assign prod_ext  = {{(ACC_W-32){prod[31]}}, prod};
   assign acc_sum   = acc + prod_ext;
   assign transfer  = prod_valid && (state == ACC);
   assign count_inc = count + LEN_W'(1);
   assign clipped   = saturate(acc_sum);

   always_comb begin
      state_next = state;
      acc_next   = acc;
      count_next = count;
      len_next   = len_latched;
      sum_next   = sum;
      sat_next   = sat;
      case (state)
         IDLE: begin
            if (start) begin
               len_next   = len;
               acc_next   = '0;
               count_next = '0;
               if (len == '0) begin
                  state_next = DONE;
                  sum_next   = '0;
                  sat_next   = 1'b0;
               end else begin
                  state_next = ACC;
               end
            end
         end
         ACC: begin
            if (transfer) begin
               acc_next   = acc_sum;
               count_next = count_inc;
               // The result is registered on the final transfer so it is ready with sum_valid.
               if (count_inc == len_latched) begin
                  state_next = DONE;
                  sum_next   = clipped[31:0];
                  sat_next   = clipped[32];
               end
            end
         end
         DONE: begin
            if (sum_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         count       <= '0;
         len_latched <= '0;
         sum         <= '0;
         sat         <= 1'b0;
      end else begin
         state       <= state_next;
         acc         <= acc_next;
         count       <= count_next;
         len_latched <= len_next;
         sum         <= sum_next;
         sat         <= sat_next;
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Table-driven bench for product_accumulator: each vector is one accumulation run,
// expected results go through a scoreboard queue and are checked when sum_valid appears.
module tb_product_accumulator;

   localparam int LEN_W = 8;
   localparam int ACC_W = 40;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] len;
   logic [31:0]      prod;
   logic             prod_valid;
   logic             prod_ready;
   logic [31:0]      sum;
   logic             sat;
   logic             sum_valid;
   logic             sum_ready;
   logic             busy;
   logic [LEN_W-1:0] count;

   product_accumulator #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .len        (len),
      .prod       (prod),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .sum        (sum),
      .sat        (sat),
      .sum_valid  (sum_valid),
      .sum_ready  (sum_ready),
      .busy       (busy),
      .count      (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               len;
      logic [3:0][31:0] p;
      logic [3:0][1:0]  gaps;      // idle cycles inserted before each product
      bit               start_in_gap;
      int               hold;      // cycles of sum_ready=0 backpressure
      logic [31:0]      exp_sum;
      logic             exp_sat;
   } vec_t;

   vec_t        vecs[6];
   logic [32:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic vec_t mk(input int l, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [31:0] d,
                               input logic [1:0] g1, input logic [1:0] g2, input bit sig,
                               input int hold, input logic [31:0] es, input logic esat);
      vec_t v;
      v.len = l;
      v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
      v.gaps[0] = 2'd0; v.gaps[1] = g1; v.gaps[2] = g2; v.gaps[3] = 2'd0;
      v.start_in_gap = sig;
      v.hold = hold;
      v.exp_sum = es;
      v.exp_sat = esat;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int id, input vec_t v);
      logic [31:0] held_sum;
      logic        held_sat;
      logic [32:0] e;
      int          k;
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_prod_ready", 64'(prod_ready), 64'd0);
      check("idle_sum_valid", 64'(sum_valid), 64'd0);
      exp_q.push_back({v.exp_sat, v.exp_sum});
      start = 1'b1;
      len   = LEN_W'(v.len);
      step();
      start = 1'b0;
      len   = 8'hFF;  // must be ignored once latched
      check("busy_after_start", 64'(busy), 64'd1);
      for (int i = 0; i < v.len; i++) begin
         for (int g = 0; g < int'(v.gaps[i]); g++) begin
            prod_valid = 1'b0;
            prod       = $urandom;
            if (v.start_in_gap) begin
               start = 1'b1;
               len   = 8'd1;
            end
            step();
            start = 1'b0;
            check("gap_count_hold", 64'(count), 64'(i));
         end
         prod_valid = 1'b1;
         prod       = v.p[i];
         k = 0;
         while (!prod_ready && k < 20) begin
            step();
            k++;
         end
         check("prod_ready_in_acc", 64'(prod_ready), 64'd1);
         step();
      end
      prod_valid = 1'b0;
      check("sum_valid_latency", 64'(sum_valid), 64'd1);
      check("final_count", 64'(count), 64'(v.len));
      if (exp_q.size() == 0) begin
         check("scoreboard_nonempty", 64'd0, 64'd1);
      end else begin
         e = exp_q.pop_front();
         check("sum", 64'(sum), 64'(e[31:0]));
         check("sat", 64'(sat), 64'(e[32]));
      end
      $display("run %0d: len=%0d sum=%0h sat=%0b", id, v.len, sum, sat);
      held_sum   = sum;
      held_sat   = sat;
      prod_valid = 1'b1;  // upstream keeps offering; must stall
      prod       = 32'h1234_5678;
      for (int h = 0; h < v.hold; h++) begin
         step();
         check("hold_sum", 64'(sum), 64'(held_sum));
         check("hold_sat", 64'(sat), 64'(held_sat));
         check("hold_sum_valid", 64'(sum_valid), 64'd1);
         check("hold_prod_ready", 64'(prod_ready), 64'd0);
      end
      prod_valid = 1'b0;
      sum_ready  = 1'b1;
      start      = 1'b1;  // coincident start must be ignored
      len        = 8'd2;
      step();
      sum_ready = 1'b0;
      start     = 1'b0;
      check("release_sum_valid", 64'(sum_valid), 64'd0);
      check("release_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      len        = '0;
      prod       = '0;
      prod_valid = 1'b0;
      sum_ready  = 1'b0;

      vecs[0] = mk(4, 32'd12, 32'd6, 32'd25, 32'hFFFF_FF7E, 2'd0, 2'd0, 1'b0, 0, 32'hFFFF_FFA9, 1'b0);
      vecs[1] = mk(2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1, 32'h7FFF_FFFF, 1'b1);
      vecs[2] = mk(2, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1, 32'h8000_0000, 1'b1);
      vecs[3] = mk(3, 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFE, 32'd0, 2'd0, 2'd0, 1'b0, 0, 32'h7FFF_FFFE, 1'b0);
      vecs[4] = mk(0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 5, 32'd0, 1'b0);
      vecs[5] = mk(3, 32'd5, 32'd7, 32'd9, 32'd0, 2'd2, 2'd1, 1'b1, 2, 32'd21, 1'b0);

      #12;
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_sat", 64'(sat), 64'd0);
      check("rst_sum_valid", 64'(sum_valid), 64'd0);
      check("rst_prod_ready", 64'(prod_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 6; i++)
         run(i, vecs[i]);

      // Abort a len=4 run after two products with an asynchronous reset.
      start = 1'b1;
      len   = 8'd4;
      step();
      start      = 1'b0;
      prod_valid = 1'b1;
      prod       = 32'd100;
      step();
      prod = 32'd200;
      step();
      prod_valid = 1'b0;
      check("pre_rst_count", 64'(count), 64'd2);
      #2;
      rst = 1'b1;
      #1;
      check("midrun_rst_sum", 64'(sum), 64'd0);
      check("midrun_rst_sat", 64'(sat), 64'd0);
      check("midrun_rst_sum_valid", 64'(sum_valid), 64'd0);
      check("midrun_rst_prod_ready", 64'(prod_ready), 64'd0);
      check("midrun_rst_busy", 64'(busy), 64'd0);
      check("midrun_rst_count", 64'(count), 64'd0);
      #3;
      rst = 1'b0;
      step();
      run(6, mk(1, 32'hFFFF_FFF6, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 0, 32'hFFFF_FFF6, 1'b0));

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
